// File: rtl/tank_sprite_mapper.sv
// -----------------------------------------------------------------------------
// tank_sprite_mapper
// Renders up to NUM_TANKS square tank sprites over a background colour.
// Two-stage pixel pipeline: stage 1 registers the per-tank hit and flash-phase
// vectors; stage 2 selects the lowest-index hit tank and registers the colour.
// Tank positions and alive flags are double-buffered at FrameStart so a frame
// never shows a half-updated scene. Each tank has an 8-bit hit-flash counter.
//
// Ports
//   Clk         pixel clock, all state on rising edge
//   Reset_n     asynchronous active-low reset
//   FrameStart  one-cycle pulse at start of vertical blank
//   TankX/TankY packed 10-bit top-left coordinates, tank i at [10i+9:10i]
//   TankColor   packed 24-bit {R,G,B} per tank (used live)
//   TankAlive   per-tank draw enable, latched with positions
//   TankHit     per-tank one-cycle hit pulse (restarts the flash count)
//   DrawX/DrawY current pixel coordinate
//   Red/Green/Blue registered pixel colour, valid two clocks after DrawX/DrawY
//   Flashing    1 while the tank's flash counter is nonzero
// -----------------------------------------------------------------------------
module tank_sprite_mapper #(
    parameter int          NUM_TANKS    = 2,
    parameter int          SPRITE_SIZE  = 32,
    parameter int          FLASH_FRAMES = 30,
    parameter int          BLINK_BIT    = 2,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      FrameStart,
    input  logic [10*NUM_TANKS-1:0]   TankX,
    input  logic [10*NUM_TANKS-1:0]   TankY,
    input  logic [24*NUM_TANKS-1:0]   TankColor,
    input  logic [NUM_TANKS-1:0]      TankAlive,
    input  logic [NUM_TANKS-1:0]      TankHit,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue,
    output logic [NUM_TANKS-1:0]      Flashing
);

    logic [9:0]           shx_q   [NUM_TANKS];
    logic [9:0]           shy_q   [NUM_TANKS];
    logic [NUM_TANKS-1:0] sha_q;
    logic [7:0]           cnt_q   [NUM_TANKS];
    logic [7:0]           cnt_d   [NUM_TANKS];
    logic [NUM_TANKS-1:0] hit_q;
    logic [NUM_TANKS-1:0] hit_d;
    logic [NUM_TANKS-1:0] phase_q;
    logic [NUM_TANKS-1:0] phase_d;
    logic [23:0]          rgb_q;
    logic [23:0]          rgb_d;

    // Stage 1: rectangle hit test against shadow positions, 11-bit sums so
    // sprites near the right/bottom edge do not wrap back to column/row 0.
    always_comb begin
        hit_d   = '0;
        phase_d = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            logic [10:0] x_lo;
            logic [10:0] y_lo;
            logic [10:0] x_hi;
            logic [10:0] y_hi;
            x_lo = {1'b0, shx_q[i]};
            y_lo = {1'b0, shy_q[i]};
            x_hi = x_lo + 11'(SPRITE_SIZE);
            y_hi = y_lo + 11'(SPRITE_SIZE);
            hit_d[i] = sha_q[i]
                     && ({1'b0, DrawX} >= x_lo) && ({1'b0, DrawX} < x_hi)
                     && ({1'b0, DrawY} >= y_lo) && ({1'b0, DrawY} < y_hi);
            phase_d[i] = (cnt_q[i] != 8'd0) && cnt_q[i][BLINK_BIT];
        end
    end

    // Stage 2: fixed priority select; walking from the highest index down
    // leaves the lowest-index hit tank as the final winner.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            rgb_d = hit_q[i] ? (phase_q[i] ? 24'hFFFFFF : TankColor[24*i +: 24])
                             : rgb_d;
        end
    end

    // Flash counter next state: a hit reload beats the frame decrement.
    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (TankHit[i]) begin
                cnt_d[i] = 8'(FLASH_FRAMES);
            end else if (FrameStart && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Shadow registers, flash counters and both pipeline stages.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_TANKS; i++) begin
                shx_q[i] <= 10'd0;
                shy_q[i] <= 10'd0;
                cnt_q[i] <= 8'd0;
            end
            sha_q   <= '0;
            hit_q   <= '0;
            phase_q <= '0;
            rgb_q   <= 24'h000000;
        end else begin
            if (FrameStart) begin
                for (int i = 0; i < NUM_TANKS; i++) begin
                    shx_q[i] <= TankX[10*i +: 10];
                    shy_q[i] <= TankY[10*i +: 10];
                end
                sha_q <= TankAlive;
            end else begin
                sha_q <= sha_q;
            end
            for (int i = 0; i < NUM_TANKS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            hit_q   <= hit_d;
            phase_q <= phase_d;
            rgb_q   <= rgb_d;
        end
    end

    // Output mapping; Flashing depends only on registered counters.
    always_comb begin
        Red   = rgb_q[23:16];
        Green = rgb_q[15:8];
        Blue  = rgb_q[7:0];
        for (int i = 0; i < NUM_TANKS; i++) begin
            Flashing[i] = (cnt_q[i] != 8'd0);
        end
    end

endmodule

// File: doc/tank_sprite_mapper.md
# tank_sprite_mapper

Pipelined, parametrised successor to the tank color mapper. It renders up to NUM_TANKS axis-aligned square tank sprites over a background colour, with fixed index priority and per-tank colours. Tank positions are double-buffered at frame boundaries, and a per-tank hit-flash counter makes a tank blink for a set number of frames. It sits between the tank/game logic and the VGA output, driven by DrawX/DrawY from the VGA controller.

## Interface
- NUM_TANKS, 2: number of sprites, 1..8; index 0 has highest priority.
- SPRITE_SIZE, 32: sprite edge in pixels, 1..64.
- FLASH_FRAMES, 30: frames a tank flashes after a hit, 1..255.
- BLINK_BIT, 2: bit of the flash counter that selects the flash phase.
- BG_COLOR, 24'h000000: background {R,G,B}.
- Clk  in  1  pixel clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- FrameStart  in  1  one-cycle pulse at start of vertical blank.
- TankX  in  10*NUM_TANKS  packed top-left X per tank; tank i at [10i+9:10i].
- TankY  in  10*NUM_TANKS  packed top-left Y.
- TankColor  in  24*NUM_TANKS  packed {R,G,B} per tank.
- TankAlive  in  NUM_TANKS  tank i drawn only when 1; sampled with positions.
- TankHit  in  NUM_TANKS  one-cycle hit pulse per tank.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- Red, Green, Blue  out  8 each  registered pixel colour.
- Flashing  out  NUM_TANKS  1 while tank i flash counter is nonzero.

## Operation
- Shadow registers: on FrameStart, latch TankX, TankY and TankAlive into shadow copies. Rendering uses shadows only, so mid-frame moves never tear. TankColor is used live.
- Hit test, stage 1: tank i is hit when shadow alive, DrawX >= X_i, DrawX < X_i+SPRITE_SIZE, DrawY >= Y_i and DrawY < Y_i+SPRITE_SIZE.
  - Sums are computed 11 bits wide, so sprites near X=639/Y=479 do not wrap.
  - Register the hit vector plus the flash-phase vector.
- Select, stage 2: pick the lowest-index hit tank.
  - If that tank is in flash phase (counter nonzero and counter[BLINK_BIT]=1), output 24'hFFFFFF.
  - Otherwise output its TankColor.
  - If no tank is hit, output BG_COLOR. Register the result onto Red/Green/Blue.
- Flash counter per tank, 8 bits:
  - TankHit[i] loads FLASH_FRAMES.
  - Else FrameStart decrements it if nonzero.
  - It saturates at 0.
  - Flashing[i] = (counter != 0).
- Simultaneous TankHit[i] and FrameStart: load wins, no decrement that cycle.
- Hit during flash restarts the count at FLASH_FRAMES.
- Reset (any time, asynchronous): shadows, counters, pipeline registers and RGB clear to 0. Shadow TankAlive = 0, so only BG_COLOR renders until the first FrameStart.

## Timing
- Latency: DrawX/DrawY at edge n give RGB valid after edge n+2. The throughput is one pixel per clock.
- Shadow update visible from pixels presented the cycle after the FrameStart edge.
- Counter change visible in the flash phase from pixels presented the cycle after the edge.
- Reset values: Red=Green=Blue=8'h00, Flashing=0. The first pipeline output after reset release is BG_COLOR, 2 cycles later.
- No handshake: the block is free-running; DrawX/DrawY are assumed to change at most once per clock.

## Test plan
- Defaults, tank0 at (100,50) red FF0000 alive, FrameStart. Sweep DrawX 99..132 at DrawY=60:
  - RGB = 000000 at X=99 and X=132.
  - RGB = FF0000 for X=100..131.
  - Each output appears 2 cycles after its DrawX.
- Overlap, tank0 (100,100) red and tank1 (110,110) blue, pixel (115,115):
  - Output is FF0000 (priority).
  - With TankAlive[0]=0 after the next FrameStart, output is 0000FF.
- Edge/no-wrap, tank0 at X=620 and Y=460:
  - Pixel (639,479) is coloured.
  - Pixel (5,470) is background.
- Tearing, tank0 moved from (0,0) to (200,200) mid-frame without FrameStart:
  - Pixel (10,10) still coloured.
  - After FrameStart, (10,10) is background and (210,210) is coloured.
- Flash:
  - TankHit[0] gives Flashing[0]=1 and counter 30 (bit2=1, white).
  - After 2 FrameStarts the counter is 28 (white); after 6, 24 (normal colour).
  - After 30 FrameStarts, Flashing[0]=0.
  - TankHit coincident with FrameStart gives counter 30, not 29.
- Reset_n pulsed low mid-frame during flash:
  - RGB and Flashing go 0 immediately (asynchronously).
  - Background only until the next FrameStart.
